// File: rtl/fix2flt_sequencer.sv
// fix2flt_sequencer: converts one sign-magnitude 16-bit fixed-point operand
// held in byte memory into float16 and writes the result back.
// The magnitude is normalized with one left shift per cycle.
module fix2flt_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int IN_LO_ADDR  = 0,
    parameter int IN_HI_ADDR  = 1,
    parameter int OUT_LO_ADDR = 2,
    parameter int OUT_HI_ADDR = 3,
    parameter int EXP_TOP     = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, NORM, WR_LO, WR_HI, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [14:0] mag;
    logic [4:0]  exp_q;
    logic        sign;
    logic [15:0] result;

    // A zero magnitude never normalizes, so it bypasses the exponent and
    // keeps only its sign (0x8000 stays 0x8000). Mantissa is truncated.
    assign result = (mag == 15'd0) ? {sign, 15'd0} : {sign, exp_q, mag[13:4]};

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand capture and one-bit-per-cycle normalization.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mag   <= '0;
            exp_q <= '0;
            sign  <= 1'b0;
        end else begin
            case (state)
                RD_LO: mag[7:0] <= mem_rd_data;
                RD_HI: begin
                    sign      <= mem_rd_data[7];
                    mag[14:8] <= mem_rd_data[6:0];
                    exp_q     <= 5'(EXP_TOP);
                end
                NORM: if (mag != 15'd0 && !mag[14]) begin
                    mag   <= mag << 1;
                    exp_q <= exp_q - 5'd1;
                end
                default: ;
            endcase
        end
    end

    // Next-state and Moore outputs decoded from the current state.
    always_comb begin
        state_nxt   = state;
        done        = 1'b0;
        busy        = 1'b1;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = RD_LO;
            end
            RD_LO: begin
                mem_addr  = ADDR_W'(IN_LO_ADDR);
                state_nxt = RD_HI;
            end
            RD_HI: begin
                mem_addr  = ADDR_W'(IN_HI_ADDR);
                state_nxt = NORM;
            end
            NORM: begin
                if (mag == 15'd0 || mag[14]) state_nxt = WR_LO;
            end
            WR_LO: begin
                mem_addr    = ADDR_W'(OUT_LO_ADDR);
                mem_wr_en   = 1'b1;
                mem_wr_data = result[7:0];
                state_nxt   = WR_HI;
            end
            WR_HI: begin
                mem_addr    = ADDR_W'(OUT_HI_ADDR);
                mem_wr_en   = 1'b1;
                mem_wr_data = result[15:8];
                state_nxt   = DONE;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b0;
                if (start) state_nxt = RD_LO;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fix2flt_sequencer.sv
// Self-checking bench for fix2flt_sequencer: directed vector table, busy-start
// and mid-conversion reset sequences, and random operands against a model.
module tb_fix2flt_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done, busy, mem_wr_en;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data;

    logic [7:0] mem [256];
    int         wr_cnt = 0;
    int         bad_wr = 0;
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;

    fix2flt_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
    );

    // Behavioural memory: combinational read, write on the rising edge.
    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_cnt = wr_cnt + 1;
            if (mem_addr != 8'd2 && mem_addr != 8'd3) bad_wr = bad_wr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        else n_pass++;
    endtask

    // Reference: shift the magnitude up until bit 14 is set, counting shifts.
    function automatic void model(input logic [15:0] op, output logic [15:0] r, output int lat);
        int m = int'(op[14:0]);
        int k = 0;
        if (m == 0) begin
            r   = {op[15], 15'd0};
            lat = 5;
        end else begin
            while (m < 16384) begin
                m = m * 2;
                k++;
            end
            r   = {op[15], 5'(21 - k), 10'((m % 16384) / 16)};
            lat = 5 + k;
        end
    endfunction

    // Load an operand, pulse start, count cycles until done.
    task automatic run_conv(input logic [15:0] op, output logic [15:0] res,
                            output int lat, output int writes);
        int w0;
        mem[0] = op[7:0];
        mem[1] = op[15:8];
        w0 = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_drops_on_start", {31'd0, done}, 32'd0);
        lat = 40;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        res    = {mem[3], mem[2]};
        writes = wr_cnt - w0;
    endtask

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
        int          lat;
    } vec_t;

    initial begin
        vec_t        vecs [7];
        logic [15:0] r, er, op;
        int          lat, elat, wr, w0;

        vecs[0] = '{16'h7FFF, 16'h57FF, 5};
        vecs[1] = '{16'h0001, 16'h1C00, 19};
        vecs[2] = '{16'hFFFF, 16'hD7FF, 5};
        vecs[3] = '{16'h0030, 16'h3200, 14};
        vecs[4] = '{16'h8000, 16'h8000, 5};
        vecs[5] = '{16'h0000, 16'h0000, 5};
        vecs[6] = '{16'h4000, 16'h5400, 5};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b0;
        start = 1'b0;
        #12;
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_wr_en", {31'd0, mem_wr_en}, 0);
        chk("rst_addr", {24'd0, mem_addr}, 0);
        chk("rst_wr_data", {24'd0, mem_wr_data}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table; consecutive entries also exercise restart from DONE.
        foreach (vecs[i]) begin
            run_conv(vecs[i].op, r, lat, wr);
            chk($sformatf("vec%0d_result", i), {16'd0, r}, {16'd0, vecs[i].res});
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_writes", i), wr, 2);
        end

        // Start pulsed while busy must be ignored.
        mem[0] = 8'h01;
        mem[1] = 8'h00;
        w0 = wr_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        chk("busy_start_done", {31'd0, done}, 1);
        chk("busy_start_writes", wr_cnt - w0, 2);
        chk("busy_start_result", {16'd0, mem[3], mem[2]}, 32'h1C00);

        // Asynchronous reset in the middle of normalization.
        mem[2] = 8'hAA;
        mem[3] = 8'hBB;
        mem[0] = 8'h01;
        mem[1] = 8'h00;
        w0 = wr_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_wr_en", {31'd0, mem_wr_en}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_writes", wr_cnt - w0, 0);
        chk("midrst_mem", {16'd0, mem[3], mem[2]}, 32'hBBAA);
        chk("midrst_idle_done", {31'd0, done}, 0);

        // Fresh conversion after reset release.
        run_conv(16'h0030, r, lat, wr);
        chk("post_rst_result", {16'd0, r}, 32'h3200);
        chk("post_rst_latency", lat, 14);

        // Random operands against the model.
        for (int i = 0; i < 24; i++) begin
            op = 16'($urandom);
            if (i % 4 == 1) op = op & 16'h80FF;
            if (i % 4 == 2) op = op & 16'h800F;
            model(op, er, elat);
            run_conv(op, r, lat, wr);
            chk($sformatf("rand%0d_result op=%h", i, op), {16'd0, r}, {16'd0, er});
            chk($sformatf("rand%0d_latency op=%h", i, op), lat, elat);
            chk($sformatf("rand%0d_writes", i), wr, 2);
        end

        chk("no_stray_writes", bad_wr, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fix2flt_sequencer.md
Name: fix2flt_sequencer

Overview:
- Multi-cycle controller that runs one sign-magnitude fixed(16) to float16 conversion.
- Sits between the top-level start/done handshake and the 8-bit data memory.
- Reads the operand bytes from memory, normalizes with one shift per cycle, packs {sign,exp,mant} and writes the two result bytes back.
- Holds done until the next start.

Parameters:
- ADDR_W, 8, memory address width.
- IN_LO_ADDR, 0, operand low byte address.
- IN_HI_ADDR, 1, operand high byte address.
- OUT_LO_ADDR, 2, result low byte address.
- OUT_HI_ADDR, 3, result high byte address.
- EXP_TOP, 21, exponent assigned when magnitude bit 14 is already set.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- done  out  1  conversion complete; level, held until next accepted start.
- busy  out  1  high in every state except IDLE and DONE.
- mem_addr  out  ADDR_W  memory address, Moore-decoded from state.
- mem_rd_data  in  8  memory read data; combinational read of mem_addr.
- mem_wr_en  out  1  memory write strobe; write takes effect on the clk edge.
- mem_wr_data  out  8  memory write data.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; done=0, busy=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0; internal mag/exp/sign cleared.
- Reset mid-operation aborts the conversion; no further writes occur.
- States: IDLE, RD_LO, RD_HI, NORM, WR_LO, WR_HI, DONE.
- IDLE: start=1 -> RD_LO; otherwise stay.
- RD_LO: mem_addr=IN_LO_ADDR; latch mag[7:0]=mem_rd_data -> RD_HI.
- RD_HI: mem_addr=IN_HI_ADDR; latch sign=mem_rd_data[7] and mag[14:8]=mem_rd_data[6:0]; exp=EXP_TOP -> NORM.
- NORM, zero trap: if mag==0 -> WR_LO; result is {sign,15'b0} (0x8000 stays 0x8000).
- NORM, normalized: else if mag[14]=1 -> WR_LO.
- NORM, shift: else mag<=mag<<1, exp<=exp-1, stay in NORM.
- NORM bounds: at most 14 shift cycles; exp never below 7 for nonzero input.
- Result packing: result={sign, exp[4:0], mag[13:4]}. Mantissa is truncated, with no rounding; mag[3:0] are discarded.
- WR_LO: mem_addr=OUT_LO_ADDR, mem_wr_en=1, mem_wr_data=result[7:0] -> WR_HI.
- WR_HI: mem_addr=OUT_HI_ADDR, mem_wr_en=1, mem_wr_data=result[15:8] -> DONE.
- DONE: done=1, busy=0.
  - start=1 -> RD_LO, and done drops the same edge.
  - Otherwise stay in DONE.
- mem_wr_en is 1 only in WR_LO and WR_HI; exactly two writes per conversion.
- Latency: with start sampled at edge E0 and k shifts, done rises after edge E0+k+5. Range 5..19 cycles.
- start while busy=1 is ignored; there is no queuing.
- start held high continuously: after each DONE cycle a new conversion begins.
- Memory contents outside addresses 2/3 are never written.

Test Plan:
- Operand 0x7FFF (k=0) -> memory[3:2]=0x57FF; done high exactly 5 cycles after the start edge; exactly two writes observed.
- Operand 0x0001 (k=14) -> 0x1C00 after 19 cycles. Operand 0xFFFF -> 0xD7FF. Operand 0x0030 -> 0x3200.
- Operands 0x8000 -> 0x8000 and 0x0000 -> 0x0000 via zero trap, with no NORM shifts (latency 5).
- Pulse start again while busy -> ignored; a single result and a single done.
- Start pulsed in DONE with a new operand 0x4000 -> done drops next edge, result 0x5400.
- Assert reset low during NORM -> done=0, busy=0, mem_wr_en=0 immediately; addresses 2/3 unchanged.
- After release of reset, a fresh start converts normally.
- Random operands (≥20) -> result matches the normalize/truncate model above; the cycle count per operand equals 5 plus the number of leading zeros of mag[14:0] (0 when mag is zero).
